// File: rtl/rmii_udp_tx_pkg.sv
// Shared types and constants for the RMII UDP transmitter: FSM states, frame layout
// constants and the reflected CRC-32 two-bit step.
package rmii_udp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6
  } state_t;

  localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [10:0] PREAMBLE_BYTES = 11'd8;
  localparam logic [10:0] HDR_BYTES      = 11'd42;
  localparam logic [10:0] MIN_PAYLOAD    = 11'd18;
  localparam logic [10:0] IFG_CYCLES     = 11'd48;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;

  // Bit 0 of the dibit goes on the wire first, so it is folded in first.
  function automatic logic [31:0] crc_step2(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/rmii_udp_tx_crc32_d2.sv
// CRC-32 (Ethernet FCS) engine advancing two bits per clock, with synchronous
// clear back to the all-ones seed and an enable for frame-data dibits.
module crc32_d2 (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [1:0]  i_dibit,
  output logic [31:0] o_crc
);
  import rmii_udp_tx_pkg::*;

  logic [31:0] r_crc;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)    r_crc <= CRC_INIT;
    else if (i_clr) r_crc <= CRC_INIT;
    else if (i_en)  r_crc <= crc_step2(r_crc, i_dibit);
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/rmii_udp_tx.sv
// Ethernet II / IPv4 / UDP frame builder driving RMII TXD two bits per clock.
// Define RMII_UDP_TX_IP_CSUM_EN to compute the IPv4 header checksum; otherwise it is 0x0000.
module rmii_udp_tx #(
  parameter logic [47:0] SRC_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [47:0] DST_MAC  = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP   = 32'hC0A8_0002,
  parameter logic [31:0] DST_IP   = 32'hC0A8_0003,
  parameter logic [15:0] SRC_PORT = 16'd1234,
  parameter logic [15:0] DST_PORT = 16'd1234,
  parameter logic [10:0] MAX_LEN  = 11'd1472
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        tx_start,
  input  logic [10:0] tx_len,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        pl_req,
  input  logic [7:0]  pl_data,
  output logic        rmii_txen,
  output logic [1:0]  rmii_txdata,
  output logic [2:0]  o_dbg_state
);
  import rmii_udp_tx_pkg::*;

  state_t       r_state, w_next;
  logic [10:0]  r_len, r_cnt;
  logic [1:0]   r_dibit;
  logic [15:0]  r_ident;
  logic [7:0]   r_pl_byte;
  logic         r_pl_cap, r_txen;
  logic [1:0]   r_txd;
  logic         w_accept, w_byte_end, w_txen, w_crc_en, w_crc_clr;
  logic [7:0]   w_byte;
  logic [1:0]   w_dibit;
  logic [15:0]  w_tot_len, w_udp_len, w_csum;
  logic [335:0] w_hdr;
  logic [8:0]   w_hbit;
  logic [31:0]  w_crc;

  assign w_accept   = (r_state == ST_IDLE) && tx_start;
  assign w_byte_end = (r_dibit == 2'd3);
  assign w_tot_len  = 16'd28 + {5'd0, r_len};
  assign w_udp_len  = 16'd8 + {5'd0, r_len};

  assign w_hdr = {DST_MAC, SRC_MAC, ETH_TYPE_IPV4, 8'h45, 8'h00, w_tot_len, r_ident,
                  16'h4000, 8'h40, IP_PROTO_UDP, w_csum, SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, w_udp_len, 16'h0000};
  assign w_hbit = 9'd335 - {r_cnt[5:0], 3'b000};

`ifdef RMII_UDP_TX_IP_CSUM_EN
  // One header word per preamble cycle; done long before the checksum bytes go out.
  logic [19:0] r_csum_acc;
  logic [15:0] w_csum_word;
  logic [4:0]  w_pidx;
  logic [16:0] w_fold1, w_fold2;

  assign w_pidx = {r_cnt[2:0], r_dibit};

  always_comb begin
    w_csum_word = 16'h0000;
    case (w_pidx)
      5'd0:    w_csum_word = 16'h4500;
      5'd1:    w_csum_word = w_tot_len;
      5'd2:    w_csum_word = r_ident;
      5'd3:    w_csum_word = 16'h4000;
      5'd4:    w_csum_word = {8'h40, IP_PROTO_UDP};
      5'd5:    w_csum_word = SRC_IP[31:16];
      5'd6:    w_csum_word = SRC_IP[15:0];
      5'd7:    w_csum_word = DST_IP[31:16];
      5'd8:    w_csum_word = DST_IP[15:0];
      default: w_csum_word = 16'h0000;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)        r_csum_acc <= '0;
    else if (w_accept) r_csum_acc <= '0;
    else if (r_state == ST_PREAMBLE && w_pidx < 5'd9)
      r_csum_acc <= r_csum_acc + {4'h0, w_csum_word};
  end

  assign w_fold1 = {1'b0, r_csum_acc[15:0]} + {13'd0, r_csum_acc[19:16]};
  assign w_fold2 = {1'b0, w_fold1[15:0]} + {16'd0, w_fold1[16]};
  assign w_csum  = ~w_fold2[15:0];
`else
  assign w_csum = 16'h0000;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (tx_start) w_next = ST_PREAMBLE;
      ST_PREAMBLE: if (w_byte_end && r_cnt == PREAMBLE_BYTES - 11'd1) w_next = ST_HEADER;
      ST_HEADER:   if (w_byte_end && r_cnt == HDR_BYTES - 11'd1)
                     w_next = (r_len != 11'd0) ? ST_PAYLOAD : ST_PAD;
      ST_PAYLOAD:  if (w_byte_end && r_cnt == r_len - 11'd1)
                     w_next = (r_len < MIN_PAYLOAD) ? ST_PAD : ST_FCS;
      ST_PAD:      if (w_byte_end && r_cnt == MIN_PAYLOAD - 11'd1) w_next = ST_FCS;
      ST_FCS:      if (w_byte_end && r_cnt == 11'd3) w_next = ST_IFG;
      ST_IFG:      if (r_cnt == IFG_CYCLES - 11'd1) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_byte    = 8'h00;
    w_txen    = 1'b1;
    w_crc_en  = 1'b0;
    w_crc_clr = 1'b0;
    pl_req    = 1'b0;
    case (r_state)
      ST_PREAMBLE: begin
        w_byte    = (r_cnt == PREAMBLE_BYTES - 11'd1) ? 8'hD5 : 8'h55;
        w_crc_clr = 1'b1;
      end
      ST_HEADER: begin
        w_byte   = w_hdr[w_hbit -: 8];
        w_crc_en = 1'b1;
        pl_req   = (r_dibit == 2'd2) && (r_cnt == HDR_BYTES - 11'd1) && (r_len != 11'd0);
      end
      ST_PAYLOAD: begin
        w_byte   = r_pl_byte;
        w_crc_en = 1'b1;
        pl_req   = (r_dibit == 2'd2) && (r_cnt != r_len - 11'd1);
      end
      ST_PAD: w_crc_en = 1'b1;
      ST_FCS: begin
        case (r_cnt[1:0])
          2'd0:    w_byte = ~w_crc[7:0];
          2'd1:    w_byte = ~w_crc[15:8];
          2'd2:    w_byte = ~w_crc[23:16];
          default: w_byte = ~w_crc[31:24];
        endcase
      end
      default: w_txen = 1'b0;
    endcase
  end

  always_comb begin
    case (r_dibit)
      2'd0:    w_dibit = w_byte[1:0];
      2'd1:    w_dibit = w_byte[3:2];
      2'd2:    w_dibit = w_byte[5:4];
      default: w_dibit = w_byte[7:6];
    endcase
  end

  assign tx_busy     = (r_state != ST_IDLE);
  assign tx_done     = (r_state == ST_IFG) && (r_cnt == 11'd0);
  assign o_dbg_state = r_state;
  assign rmii_txen   = r_txen;
  assign rmii_txdata = r_txd;

  // Counters restart on every state change, except that pad continues the payload byte count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_dibit   <= '0;
      r_len     <= '0;
      r_ident   <= '0;
      r_pl_cap  <= 1'b0;
      r_pl_byte <= '0;
      r_txen    <= 1'b0;
      r_txd     <= 2'b00;
    end else begin
      r_txen   <= w_txen;
      r_txd    <= w_dibit;
      r_pl_cap <= pl_req;
      if (r_pl_cap) r_pl_byte <= pl_data;
      if (w_accept) r_len <= (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
      if (r_state != ST_IFG && w_next == ST_IFG) r_ident <= r_ident + 16'd1;
      if (w_next != r_state && !(r_state == ST_PAYLOAD && w_next == ST_PAD)) begin
        r_cnt   <= '0;
        r_dibit <= '0;
      end else if (r_state == ST_IFG) begin
        r_cnt <= r_cnt + 11'd1;
      end else if (r_state != ST_IDLE) begin
        r_dibit <= r_dibit + 2'd1;
        if (w_byte_end) r_cnt <= r_cnt + 11'd1;
      end
    end
  end

  crc32_d2 u_crc (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .i_clr   (w_crc_clr),
    .i_en    (w_crc_en),
    .i_dibit (w_dibit),
    .o_crc   (w_crc)
  );

endmodule

// File: tb/tb_rmii_udp_tx.sv
// Bench for rmii_udp_tx: table of frame lengths with expected counts, a byte-level
// scoreboard of whole frames, plus hand sequences for ignored start, back-to-back and mid-frame reset.
`timescale 1ns/1ps
module tb_rmii_udp_tx;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start = 1'b0;
  logic [10:0] tx_len = '0;
  logic [7:0]  pl_data = '0;
  logic        tx_busy, tx_done, pl_req, rmii_txen;
  logic [1:0]  rmii_txdata;
  logic [2:0]  dbg_state;

  always #10 sys_clk = ~sys_clk;

  rmii_udp_tx dut (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .tx_start    (tx_start),
    .tx_len      (tx_len),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .pl_req      (pl_req),
    .pl_data     (pl_data),
    .rmii_txen   (rmii_txen),
    .rmii_txdata (rmii_txdata),
    .o_dbg_state (dbg_state)
  );

  typedef struct {
    logic [10:0] tx_len;
    int          exp_len;
    int          exp_txen;
    int          exp_plreq;
  } vec_t;

  vec_t        vecs[6];
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_ident = '0;

  // Monitor / payload source state (written only by the monitor process)
  int          cyc = 0, start_cyc = 0, rise_cyc = 0, fall_cyc = 0;
  int          txen_cnt = 0, plreq_cnt = 0, done_cnt = 0, phase = 0, pl_idx = 0;
  bit          frame_done = 0, in_frame = 0, req_pending = 0;
  logic [7:0]  cur_byte = '0;
  // Written by the stimulus process
  bit          accept_expected = 0;
  logic [7:0]  pl_seed = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] crc_update(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [15:0] model_csum(input int len, input logic [15:0] id);
`ifdef RMII_UDP_TX_IP_CSUM_EN
    int s;
    s = 'h4500 + (28 + len) + int'(id) + 'h4000 + 'h4011 + 'hC0A8 + 'h0002 + 'hC0A8 + 'h0003;
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    return ~s[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [7:0] rx(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'h00;
  endfunction

  task automatic push_expected(input int len, input logic [15:0] id, input logic [7:0] seed);
    logic [7:0]  f[$];
    logic [31:0] c;
    logic [15:0] tl, ul, cs;
    logic [47:0] smac;
    tl = 16'(28 + len);
    ul = 16'(8 + len);
    cs = model_csum(len, id);
    smac = 48'h00_11_22_33_44_55;
    repeat (7) f.push_back(8'h55);
    f.push_back(8'hD5);
    repeat (6) f.push_back(8'hFF);
    for (int k = 5; k >= 0; k--) f.push_back(smac[8*k +: 8]);
    f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h45); f.push_back(8'h00);
    f.push_back(tl[15:8]); f.push_back(tl[7:0]);
    f.push_back(id[15:8]); f.push_back(id[7:0]);
    f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(8'h40); f.push_back(8'h11);
    f.push_back(cs[15:8]); f.push_back(cs[7:0]);
    f.push_back(8'hC0); f.push_back(8'hA8); f.push_back(8'h00); f.push_back(8'h02);
    f.push_back(8'hC0); f.push_back(8'hA8); f.push_back(8'h00); f.push_back(8'h03);
    f.push_back(8'h04); f.push_back(8'hD2); f.push_back(8'h04); f.push_back(8'hD2);
    f.push_back(ul[15:8]); f.push_back(ul[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    for (int k = 0; k < len; k++) f.push_back(8'(seed + 8'(k)));
    for (int k = len; k < 18; k++) f.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < f.size(); i++) c = crc_update(c, f[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) f.push_back(c[8*k +: 8]);
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  // Monitor and payload source: drives pl_data one cycle after each pl_req,
  // assembles transmitted bytes and counts strobes.
  initial begin
    forever begin
      @(posedge sys_clk); #1;
      if (req_pending) begin
        pl_data = pl_seed + 8'(pl_idx);
        pl_idx++;
      end
      @(negedge sys_clk);
      cyc++;
      req_pending = pl_req;
      if (tx_start && accept_expected) begin
        rx_q.delete();
        txen_cnt = 0; plreq_cnt = 0; done_cnt = 0; phase = 0; pl_idx = 0;
        frame_done = 0; in_frame = 0; start_cyc = cyc;
      end
      if (pl_req) plreq_cnt++;
      if (tx_done) done_cnt++;
      if (rmii_txen) begin
        if (!in_frame) rise_cyc = cyc;
        in_frame = 1;
        txen_cnt++;
        cur_byte = {rmii_txdata, cur_byte[7:2]};
        phase++;
        if (phase == 4) begin
          rx_q.push_back(cur_byte);
          phase = 0;
        end
      end else if (in_frame) begin
        in_frame = 0;
        frame_done = 1;
        fall_cyc = cyc;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && tx_busy; i++) @(posedge sys_clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int spur, input bit check_gap);
    int          prev_fall, errs, n;
    logic [15:0] id;
    logic [31:0] c;
    logic [7:0]  e;
    int          busy_cycles;
    wait_idle();
    id = exp_ident;
    pl_seed = 8'($urandom_range(0, 255));
    prev_fall = fall_cyc;
    push_expected(v.exp_len, id, pl_seed);
    @(posedge sys_clk); #1;
    tx_start = 1'b1; tx_len = v.tx_len; accept_expected = 1;
    @(posedge sys_clk); #1;
    tx_start = 1'b0; accept_expected = 0; tx_len = 11'($urandom_range(0, 2047));
    check("busy_after_start", tx_busy, 1);
    if (spur > 0) begin
      repeat (spur) @(posedge sys_clk);
      #1; tx_start = 1'b1; tx_len = 11'd5;
      @(posedge sys_clk); #1; tx_start = 1'b0;
    end
    for (int i = 0; i < 8000 && !frame_done; i++) @(posedge sys_clk);
    check("frame_end_seen", frame_done, 1);
    wait_idle();
    check("busy_released", tx_busy, 0);
    check("txen_cycles", txen_cnt, v.exp_txen);
    check("pl_req_count", plreq_cnt, v.exp_plreq);
    check("done_pulses", done_cnt, 1);
    check("start_latency", rise_cyc - start_cyc, 2);
    if (check_gap) check("ifg_gap_ge_48", (rise_cyc - prev_fall) >= 48, 1);
    n = rx_q.size();
    check("frame_len", n, exp_q.size());
    errs = 0;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (rx_q[i] !== e) errs++;
    end
    exp_q.delete();
    check("frame_bytes_bad", errs, 0);
    check("ip_total_len", {rx(24), rx(25)}, 28 + v.exp_len);
    check("ip_ident", {rx(26), rx(27)}, id);
    check("ip_csum", {rx(32), rx(33)}, model_csum(v.exp_len, id));
    check("udp_len", {rx(46), rx(47)}, 8 + v.exp_len);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < n; i++) c = crc_update(c, rx_q[i]);
    check("fcs_residue", c, 32'hDEBB_20E3);
    if (spur > 0) begin
      busy_cycles = 0;
      repeat (80) begin
        @(negedge sys_clk);
        if (tx_busy || rmii_txen) busy_cycles++;
      end
      check("ignored_start_no_frame", busy_cycles, 0);
    end
    exp_ident = exp_ident + 16'd1;
  endtask

  initial begin
    vec_t v;
    int   l;
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   l;
    vecs[0] = '{11'd100,  100,  616,  100};
    vecs[1] = '{11'd0,    0,    288,  0};
    vecs[2] = '{11'd17,   17,   288,  17};
    vecs[3] = '{11'd18,   18,   288,  18};
    vecs[4] = '{11'd1472, 1472, 6104, 1472};
    vecs[5] = '{11'd2000, 1472, 6104, 1472};

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_txen", rmii_txen, 0);
    check("rst_txdata", rmii_txdata, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_pl_req", pl_req, 0);
    @(posedge sys_clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);

    foreach (vecs[i]) run_frame(vecs[i], 0, i > 0);

    l = $urandom_range(19, 200);
    v = '{11'(l), l, 4 * (8 + 42 + l + 4), l};
    run_frame(v, 0, 1);

    // A start request in the middle of HEADER must be dropped.
    v = '{11'd40, 40, 4 * (8 + 42 + 40 + 4), 40};
    run_frame(v, 45, 0);

    // Reset in the middle of the payload.
    wait_idle();
    @(posedge sys_clk); #1;
    tx_start = 1'b1; tx_len = 11'd100; accept_expected = 1;
    @(posedge sys_clk); #1;
    tx_start = 1'b0; accept_expected = 0;
    for (int i = 0; i < 1000 && plreq_cnt < 10; i++) @(posedge sys_clk);
    check("reached_payload", plreq_cnt >= 10, 1);
    #3 rst_n = 1'b0;
    #1;
    check("reset_txen_async", rmii_txen, 0);
    check("reset_busy", tx_busy, 0);
    exp_ident = '0;
    repeat (3) @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    v = '{11'd30, 30, 4 * (8 + 42 + 30 + 4), 30};
    run_frame(v, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
